// File: rtl/pipelined_adder_pkg.sv
// adder_pkg: shared types and configuration checks for the pipelined adder.
package adder_pkg;
   typedef enum logic {ADD_WRAP = 1'b0, ADD_SAT = 1'b1} adder_mode_e;
   function automatic bit legal_cfg(input int width, input int stages);
      return width >= 1 && stages >= 1 && stages <= width && width % stages == 0;
   endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand and result handshake bundle; master = producer/consumer, slave = adder.
interface pipelined_adder_if #(parameter int WIDTH = 8) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   modport master (
      output in_valid, in_a, in_b, in_cin, in_sat, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );
   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sat, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/pipelined_adder_slice.sv
// adder_slice: combinational SW-bit add with carry in and carry out.
module adder_slice #(parameter int SW = 1) (
   input  logic [SW-1:0] i_a,
   input  logic [SW-1:0] i_b,
   input  logic          i_cin,
   output logic [SW-1:0] o_sum,
   output logic          o_cout
);
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add with carry chain split into STAGES registered slices, valid/ready on both sides.
module pipelined_adder import adder_pkg::*; #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   pipelined_adder_if.slave bus
);
   localparam int SW = WIDTH / STAGES;
   if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: illegal WIDTH/STAGES combination");
   end
   logic [STAGES-1:0] r_v;
   logic [WIDTH-1:0]  r_a [STAGES];
   logic [WIDTH-1:0]  r_b [STAGES];
   logic [WIDTH-1:0]  r_s [STAGES];
   logic              r_c [STAGES];
   adder_mode_e       r_mode [STAGES];
   logic [STAGES-1:0] w_rdy;
   logic              w_acc;
   logic [STAGES-1:0] w_vin;
   logic              w_cin [STAGES];
   logic [WIDTH-1:0]  w_ain [STAGES];
   logic [WIDTH-1:0]  w_bin [STAGES];
   logic [WIDTH-1:0]  w_sin [STAGES];
   adder_mode_e       w_mode [STAGES];
   logic [SW-1:0]     w_ssum [STAGES];
   logic              w_sc [STAGES];
   // A stage can load if it is empty or everything downstream can move.
   always_comb begin
      w_acc = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_acc    = w_acc | !r_v[k];
         w_rdy[k] = w_acc;
      end
   end
   always_comb begin
      w_vin[0]  = bus.in_valid;
      w_ain[0]  = bus.in_a;
      w_bin[0]  = bus.in_b;
      w_cin[0]  = bus.in_cin;
      w_sin[0]  = '0;
      w_mode[0] = bus.in_sat ? ADD_SAT : ADD_WRAP;
      for (int k = 1; k < STAGES; k++) begin
         w_vin[k]  = r_v[k-1];
         w_ain[k]  = r_a[k-1];
         w_bin[k]  = r_b[k-1];
         w_cin[k]  = r_c[k-1];
         w_sin[k]  = r_s[k-1];
         w_mode[k] = r_mode[k-1];
      end
   end
   for (genvar g = 0; g < STAGES; g++) begin : g_slice
      adder_slice #(.SW(SW)) u_slice (
         .i_a   (w_ain[g][g*SW +: SW]),
         .i_b   (w_bin[g][g*SW +: SW]),
         .i_cin (w_cin[g]),
         .o_sum (w_ssum[g]),
         .o_cout(w_sc[g])
      );
   end
   // Data only moves with a valid beat, so idle operand garbage never reaches the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]    <= '0;
            r_b[k]    <= '0;
            r_s[k]    <= '0;
            r_c[k]    <= 1'b0;
            r_mode[k] <= ADD_WRAP;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_v[k] <= w_vin[k];
               if (w_vin[k]) begin
                  r_a[k]               <= w_ain[k];
                  r_b[k]               <= w_bin[k];
                  r_s[k]               <= w_sin[k];
                  r_s[k][k*SW +: SW]   <= w_ssum[k];
                  r_c[k]               <= w_sc[k];
                  r_mode[k]            <= w_mode[k];
               end
            end
         end
      end
   end
   assign bus.in_ready  = w_rdy[0] & !rst;
   assign bus.out_valid = r_v[STAGES-1];
   assign bus.out_cout  = r_c[STAGES-1];
   assign bus.out_ovf   = r_c[STAGES-1];
   assign bus.out_sum   = (r_mode[STAGES-1] == ADD_SAT && r_c[STAGES-1]) ? '1 : r_s[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder against a queue-based arithmetic model.
module tb_pipelined_adder;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   n_push;
   int   n_pop;
   int   n_drop;
   logic [8:0] q [$];
   logic       prev_stall;
   logic [7:0] prev_sum;
   pipelined_adder_if #(.WIDTH(8)) bus ();
   pipelined_adder_if #(.WIDTH(1)) bus1 ();
   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sat);
      logic [8:0] f;
      f = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      return {f[8], (sat && f[8]) ? 8'hFF : f[7:0]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Scoreboard: every accepted beat is queued, every delivered result must match the head.
   always @(negedge clk) begin
      if (rst) begin
         n_drop += q.size();
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("hold_sum", 32'(bus.out_sum), 32'(prev_sum));
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'(0));
            else begin
               logic [8:0] e;
               e = q.pop_front();
               n_pop++;
               chk("sb_sum", 32'(bus.out_sum), 32'(e[7:0]));
               chk("sb_cout", 32'(bus.out_cout), 32'(e[8]));
               chk("sb_ovf", 32'(bus.out_ovf), 32'(e[8]));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sat));
            n_push++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_sum   = bus.out_sum;
      end
   end
   task automatic put(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sat);
      logic ok;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sat   = sat;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = bus.in_ready;
      end
      chk("accept", 32'(ok), 32'(1));
      step();
      bus.in_valid = 1'b0;
   endtask
   task automatic one(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sat,
                      input logic [7:0] esum, input logic ecout);
      put(a, b, cin, sat);
      @(negedge clk);
      chk("lat_early", 32'(bus.out_valid), 32'(0));
      @(negedge clk);
      chk("lat_valid", 32'(bus.out_valid), 32'(1));
      chk("dir_sum", 32'(bus.out_sum), 32'(esum));
      chk("dir_cout", 32'(bus.out_cout), 32'(ecout));
      chk("dir_ovf", 32'(bus.out_ovf), 32'(ecout));
      step();
   endtask
   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !bus.out_valid) break;
      end
      chk("drain_q", 32'(q.size()), 32'(0));
      step();
   endtask
   logic [7:0] ta [3];
   logic [7:0] tb [3];
   logic       tc [3];
   logic       ts [3];
   logic [7:0] held;
   logic [7:0] e3 [4];
   logic [1:0] ab;
   initial begin
      n_chk = 0; n_fail = 0; n_push = 0; n_pop = 0; n_drop = 0;
      prev_stall = 1'b0; prev_sum = '0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sat = 1'b0;
      bus.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.in_sat = 1'b0;
      bus1.out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_out_sum", 32'(bus.out_sum), 32'(0));
      chk("rst_cout", 32'(bus.out_cout), 32'(0));
      chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
      chk("rst1_out_valid", 32'(bus1.out_valid), 32'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
      step();
      one(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
      one(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      one(8'hFF, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
      // Four back-to-back beats at full throughput.
      e3[0] = 8'h03; e3[1] = 8'h07; e3[2] = 8'h00; e3[3] = 8'h81;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sat   = 1'b0;
         bus.in_a     = (i == 0) ? 8'd1 : (i == 1) ? 8'd3 : (i == 2) ? 8'h80 : 8'h7F;
         bus.in_b     = (i == 0) ? 8'd2 : (i == 1) ? 8'd4 : (i == 2) ? 8'h80 : 8'h01;
         bus.in_cin   = (i == 3);
         @(negedge clk);
         chk("b2b_in_ready", 32'(bus.in_ready), 32'(1));
         if (i >= 2) begin
            chk("b2b_valid", 32'(bus.out_valid), 32'(1));
            chk("b2b_sum", 32'(bus.out_sum), 32'(e3[i-2]));
         end
         step();
      end
      bus.in_valid = 1'b0;
      for (int j = 2; j < 4; j++) begin
         @(negedge clk);
         chk("b2b_valid", 32'(bus.out_valid), 32'(1));
         chk("b2b_sum", 32'(bus.out_sum), 32'(e3[j]));
         chk("b2b_cout", 32'(bus.out_cout), 32'(j == 2));
         step();
      end
      drain();
      // Stall: two beats fill the pipe, the third waits.
      for (int i = 0; i < 3; i++) begin
         ta[i] = 8'($urandom); tb[i] = 8'($urandom);
         tc[i] = 1'($urandom); ts[i] = 1'($urandom);
      end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a = ta[i]; bus.in_b = tb[i]; bus.in_cin = tc[i]; bus.in_sat = ts[i];
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'(i < 2));
         if (i < 2) step();
      end
      held = bus.out_sum;
      chk("stall_valid", 32'(bus.out_valid), 32'(1));
      chk("stall_sum", 32'(bus.out_sum), 32'(model(ta[0], tb[0], tc[0], ts[0]) & 9'h0FF));
      step();
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
         chk("stall_held", 32'(bus.out_sum), 32'(held));
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("full_passthru", 32'(bus.in_ready), 32'(1));
      step();
      drain();
      // Reset with two beats in flight.
      bus.out_ready = 1'b0;
      put(8'($urandom), 8'($urandom), 1'b0, 1'b0);
      put(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      rst = 1'b1;
      step();
      chk("midrst_valid", 32'(bus.out_valid), 32'(0));
      chk("midrst_sum", 32'(bus.out_sum), 32'(0));
      chk("midrst_cout", 32'(bus.out_cout), 32'(0));
      chk("midrst_ovf", 32'(bus.out_ovf), 32'(0));
      chk("midrst_in_ready", 32'(bus.in_ready), 32'(0));
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      one(8'd5, 8'd6, 1'b0, 1'b0, 8'd11, 1'b0);
      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(3) != 0);
         bus.in_a      = 8'($urandom);
         bus.in_b      = 8'($urandom);
         bus.in_cin    = 1'($urandom);
         bus.in_sat    = 1'($urandom);
         bus.out_ready = ($urandom_range(2) != 0);
         step();
      end
      drain();
      chk("beats_conserved", 32'(n_push), 32'(n_pop + n_drop));
      // Legacy half-adder regression on the 1-bit, 1-stage build.
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         bus1.in_valid = 1'b1;
         bus1.in_a     = ab[1];
         bus1.in_b     = ab[0];
         @(negedge clk);
         chk("ha_in_ready", 32'(bus1.in_ready), 32'(1));
         step();
         bus1.in_valid = 1'b0;
         @(negedge clk);
         chk("ha_valid", 32'(bus1.out_valid), 32'(1));
         chk("ha_sum", 32'(bus1.out_sum), 32'(ab[1] ^ ab[0]));
         chk("ha_cout", 32'(bus1.out_cout), 32'(ab[1] & ab[0]));
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
